// File: rtl/addr_gen_unit.sv
// Address generation unit: computes base+offset with a misalignment flag and
// queues the results in a small FIFO whose head is presented on registered outputs.
module addr_gen_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 3,
  parameter int unsigned OP_W  = 5,
  parameter int unsigned DEPTH = 4,
  parameter logic [OP_W-1:0] NOP = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  offset,
  input  logic [OP_W-1:0]  in_op,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [XLEN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [OP_W-1:0]  out_op,
  output logic [ROB_W-1:0] out_rob,
  output logic [XLEN-1:0]  out_data,
  output logic             out_misalign,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]  addr_mem [DEPTH];
  logic [OP_W-1:0]  op_mem   [DEPTH];
  logic [ROB_W-1:0] rob_mem  [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic             mis_mem  [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    cnt_next;
  logic [XLEN-1:0]  sum;
  logic             mis;
  logic             push, pop, from_in;

  logic             h_valid;
  logic [XLEN-1:0]  h_addr;
  logic [OP_W-1:0]  h_op;
  logic [ROB_W-1:0] h_rob;
  logic [XLEN-1:0]  h_data;
  logic             h_mis;

  // Effective address and size-based alignment check
  always_comb begin
    sum = base + offset;
    mis = 1'b0;
    case (in_op[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = sum[0];
      2'b10:   mis = |sum[1:0];
      default: mis = 1'b1;
    endcase
  end

  always_comb begin
    push     = in_valid && in_ready && !pause && !flush && rst;
    pop      = out_valid && out_ready && !pause && !flush;
    cnt_next = count + CW'(push) - CW'(pop);
    rd_next  = rd_ptr + PW'(pop);
  end

  // Next head: bypass the incoming request when it becomes the only entry
  always_comb begin
    from_in = (count == '0) || ((count == CW'(1)) && pop);
    h_valid = (cnt_next != '0);
    h_addr  = '0;
    h_op    = NOP;
    h_rob   = '0;
    h_data  = '0;
    h_mis   = 1'b0;
    if (h_valid) begin
      if (from_in) begin
        h_addr = sum;
        h_op   = in_op;
        h_rob  = in_rob;
        h_data = in_data;
        h_mis  = mis;
      end else begin
        h_addr = addr_mem[rd_next];
        h_op   = op_mem[rd_next];
        h_rob  = rob_mem[rd_next];
        h_data = data_mem[rd_next];
        h_mis  = mis_mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= sum;
      op_mem[wr_ptr]   <= in_op;
      rob_mem[wr_ptr]  <= in_rob;
      data_mem[wr_ptr] <= in_data;
      mis_mem[wr_ptr]  <= mis;
    end
  end

  // Queue control and registered head presentation; pause outranks flush
  always_ff @(posedge clk) begin
    if (!rst || (!pause && flush)) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_op       <= NOP;
      out_rob      <= '0;
      out_data     <= '0;
      out_misalign <= 1'b0;
    end else if (!pause) begin
      wr_ptr       <= wr_ptr + PW'(push);
      rd_ptr       <= rd_next;
      count        <= cnt_next;
      in_ready     <= (cnt_next < CW'(DEPTH));
      out_valid    <= h_valid;
      out_addr     <= h_addr;
      out_op       <= h_op;
      out_rob      <= h_rob;
      out_data     <= h_data;
      out_misalign <= h_mis;
    end
  end

endmodule

// File: tb/tb_addr_gen_unit.sv
// Scoreboard bench for addr_gen_unit: a queue model predicts the head entry,
// count and in_ready after every clock edge.
module tb_addr_gen_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [4:0]  NOP   = 5'h1f;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  op;
    logic [2:0]  rob;
    logic [31:0] data;
    logic        mis;
  } ent_t;

  logic        clk, rst, pause, flush, in_valid, in_ready, out_valid, out_ready, out_misalign;
  logic [31:0] base, offset, in_data, out_addr, out_data;
  logic [4:0]  in_op, out_op;
  logic [2:0]  in_rob, out_rob, count;
  logic [77:0] act;

  ent_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  addr_gen_unit #(.XLEN(32), .ROB_W(3), .OP_W(5), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .offset(offset), .in_op(in_op), .in_rob(in_rob), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_op(out_op), .out_rob(out_rob), .out_data(out_data),
    .out_misalign(out_misalign), .count(count)
  );

  assign act = {out_valid, out_addr, out_op, out_rob, out_data, out_misalign, count, in_ready};

  always #5 clk = ~clk;

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b1;
  endfunction

  function automatic logic [77:0] exp_vec();
    ent_t e;
    if (exp_q.size() == 0) return {1'b0, 32'h0, NOP, 3'h0, 32'h0, 1'b0, 3'd0, 1'b1};
    e = exp_q[0];
    return {1'b1, e.addr, e.op, e.rob, e.data, e.mis, 3'(exp_q.size()), exp_q.size() < DEPTH};
  endfunction

  task automatic drive(input logic v, input logic [31:0] b, input logic [31:0] o,
                       input logic [4:0] op, input logic [2:0] rob, input logic [31:0] d);
    in_valid = v; base = b; offset = o; in_op = op; in_rob = rob; in_data = d;
  endtask

  // Advance one edge, updating the scoreboard from the inputs seen at that edge
  task automatic tick();
    logic pu, po;
    ent_t e;
    pu = in_valid && rst && !pause && !flush && (exp_q.size() < DEPTH);
    po = rst && !pause && !flush && (exp_q.size() > 0) && out_ready;
    e.addr = base + offset;
    e.op   = in_op;
    e.rob  = in_rob;
    e.data = in_data;
    e.mis  = model_mis(e.addr, in_op[1:0]);
    @(posedge clk);
    if (!rst || (!pause && flush)) exp_q.delete();
    else if (!pause) begin
      if (po) void'(exp_q.pop_front());
      if (pu) exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pause = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    tick(); tick();
    total++;
    if (act !== exp_vec()) begin bad++; $display("FAIL reset act=%h exp=%h", act, exp_vec()); end
    total++;
    if (out_op !== NOP || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_nop op=%h rdy=%b exp op=%h rdy=1", out_op, in_ready, NOP);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 32'h1000, 32'h24, 5'b00010, 3'd5, 32'hcafe0001);
    tick();
    drive(1'b0, 0, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1'b1 || out_addr !== 32'h1024 || out_rob !== 3'd5 || out_misalign !== 1'b0) begin
      bad++; $display("FAIL basic v=%b addr=%h rob=%0d mis=%b exp v=1 addr=1024 rob=5 mis=0",
                      out_valid, out_addr, out_rob, out_misalign);
    end
    total++;
    if (act !== exp_vec()) begin bad++; $display("FAIL basic_vec act=%h exp=%h", act, exp_vec()); end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_op !== NOP) begin
      bad++; $display("FAIL basic_drain v=%b op=%h exp v=0 op=%h", out_valid, out_op, NOP);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFFFFFE, 32'h3, 5'b00001, 3'd2, 32'h12345678);
    tick();
    drive(1'b0, 0, 0, 0, 0, 0);
    total++;
    if (out_addr !== 32'h1 || out_misalign !== 1'b1 || out_data !== 32'h12345678) begin
      bad++; $display("FAIL wrap addr=%h mis=%b data=%h exp addr=1 mis=1 data=12345678",
                      out_addr, out_misalign, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (act !== exp_vec()) begin bad++; $display("FAIL wrap_drain act=%h exp=%h", act, exp_vec()); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'h0, 5'b00010, 3'(i), 32'(i) + 32'h100);
      tick();
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL full_fill%0d act=%h exp=%h", i, act, exp_vec()); end
    end
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_rob !== 3'd0) begin
      bad++; $display("FAIL full_state cnt=%0d rdy=%b rob=%0d exp cnt=4 rdy=0 rob=0", count, in_ready, out_rob);
    end
    // Pop while full with a request pending: the request must not slip in
    out_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 5'b00000, 3'd7, 32'h0);
    tick();
    drive(1'b0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_rob !== 3'(i) || count !== 3'(4 - i) || act !== exp_vec()) begin
        bad++; $display("FAIL full_order%0d rob=%0d cnt=%0d exp rob=%0d cnt=%0d", i, out_rob, count, i, 4 - i);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL full_empty v=%b cnt=%0d exp v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300, 32'(i), 5'b00000, 3'(i), 32'h0);
      tick();
    end
    total++;
    if (count !== 3'd2) begin bad++; $display("FAIL flush_pre cnt=%0d exp=2", count); end
    flush = 1'b1;
    drive(1'b1, 32'h400, 32'h0, 5'b00000, 3'd6, 32'hdead);
    tick();
    flush = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || act !== exp_vec()) begin
      bad++; $display("FAIL flush cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_rob !== 3'd0) begin
      bad++; $display("FAIL flush_ghost v=%b rob=%0d exp v=0 rob=0", out_valid, out_rob);
    end
  endtask

  task automatic test_pause();
    logic [77:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500, 32'(i * 2), 5'b00001, 3'(i + 3), 32'(i));
      tick();
    end
    held = act;
    pause = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h600, 32'h0, 5'b00010, 3'd1, 32'h66);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act !== held || count !== 3'd2 || act !== exp_vec()) begin
        bad++; $display("FAIL pause%0d act=%h exp=%h", i, act, held);
      end
    end
    pause = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL resume%0d act=%h exp=%h", i, act, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700, 32'(i), 5'b00000, 3'(i), 32'h0);
      tick();
    end
    drive(1'b0, 0, 0, 0, 0, 0);
    pause = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; pause = 1'b0;
    total++;
    if (count !== 3'd0 || out_op !== NOP || out_rob !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid cnt=%0d op=%h rob=%0d rdy=%b exp cnt=0 op=%h rob=0 rdy=1",
                      count, out_op, out_rob, in_ready, NOP);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 7), 5'($urandom),
            3'($urandom), $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      pause     = 1'($urandom_range(0, 9) == 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      tick();
      total++;
      if (act !== exp_vec()) begin bad++; $display("FAIL stream%0d act=%h exp=%h", i, act, exp_vec()); end
    end
    pause = 1'b0; flush = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_flush();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_gen_unit.md
ADDR_GEN_UNIT -- requirements
Module: addr_gen_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/address width.
REQ-002 Parameter ROB_W, default 3, ROB tag width.
REQ-003 Parameter OP_W, default 5, memory-op code width; OP_W >= 2.
REQ-004 Parameter DEPTH, default 4, result-queue entries; power of two, >= 2.
REQ-005 Parameter NOP, default all-ones (OP_W bits), op code driven when no result is presented.
REQ-006 clk  in  1  clock; all state updates on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 pause  in  1  global stall; when 1, no state changes.
REQ-009 flush  in  1  mispredict flush; discards all queued and incoming work.
REQ-010 in_valid  in  1  request present.
REQ-011 in_ready  out  1  queue can accept a request.
REQ-012 base, offset  in  XLEN each  address operands.
REQ-013 in_op  in  OP_W  memory op; bits [1:0] = size (00 byte, 01 half, 10 word, 11 reserved).
REQ-014 in_rob  in  ROB_W  ROB tag.
REQ-015 in_data  in  XLEN  store data, carried unchanged.
REQ-016 out_valid  out  1  head entry presented.
REQ-017 out_ready  in  1  consumer takes head.
REQ-018 out_addr  out  XLEN, out_op  out  OP_W, out_rob  out  ROB_W, out_data  out  XLEN  head entry fields.
REQ-019 out_misalign  out  1  head address misaligned for its size.
REQ-020 count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-021 Accept (push) occurs when in_valid && in_ready && !pause && !flush && rst.
REQ-022 On push, the entry stores addr = (base + offset) mod 2^XLEN, in_op, in_rob, in_data, and misalign flag.
REQ-023 Misalign = (size==01 && addr[0]) || (size==10 && addr[1:0]!=0) || size==11; byte never misaligned.
REQ-024 Latency: a request pushed at edge N into an empty queue shall be visible on out_* with out_valid=1 immediately after edge N.
REQ-025 out_* shall be registered from the head entry; out_valid = (count != 0).
REQ-026 When out_valid=0: out_op = NOP, out_rob = 0, out_addr/out_data/out_misalign = 0.
REQ-027 Pop occurs when out_valid && out_ready && !pause && !flush; next entry appears after that edge.
REQ-028 in_ready = (count < DEPTH); no push-through when full, even if a pop occurs in the same cycle.
REQ-029 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved (FIFO).
REQ-030 Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-031 flush=1 (and !pause): after the edge count=0, pointers=0, out_valid=0, same-cycle input dropped.
REQ-032 pause=1 freezes pointers, count, and all outputs; in_ready still reflects count; pause has priority over flush.
REQ-033 Entries exit in acceptance order; fields are never reordered or altered between push and pop.

Reset
REQ-034 rst=0 at a posedge (regardless of pause): count=0, pointers=0, out_valid=0, out_op=NOP, out_rob=0, out_addr=0, out_data=0, out_misalign=0.
REQ-035 Reset mid-operation discards all queued entries; in_ready=1 from the first cycle after reset.

Verification
REQ-036 base=0x1000, offset=0x24, op size=10, rob=5, out_ready=1 -> next cycle out_addr=0x1024, out_rob=5, out_misalign=0, then out_valid=0, out_op=NOP.
REQ-037 base=0xFFFFFFFE, offset=3, size=01 -> out_addr=0x00000001 (wrap), out_misalign=1.
REQ-038 out_ready=0, push 4 requests (DEPTH=4) -> count=4, in_ready=0; 5th request not accepted; release out_ready -> 4 entries out in order, tags 0,1,2,3.
REQ-039 count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed input never appears.
REQ-040 pause=1 for 3 cycles with in_valid=1, out_ready=1 -> count and outputs unchanged; resume -> normal flow, no loss or duplication.
REQ-041 rst=0 with count=3 and pause=1 -> after edge count=0, out_op=NOP, out_rob=0, in_ready=1.
